pipe_if_stage: RTL and testbench

PIPE_IF_STAGE -- requirements
Module: pipe_if_stage

---
 rtl/pipe_if_stage.sv | 206 ++++++++++++++++++++
 tb/tb_pipe_if_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_if_stage.sv
// ============================================================================
// Module   : pipe_if_stage
// Brief    : Instruction-fetch stage of a 5-stage pipeline. Owns the PC,
//            issues fetch requests to a variable-latency instruction memory,
//            applies redirects (branch / jr / jump), parks a returned word in
//            a skid buffer during load-use stalls, and drives the IF/ID
//            pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  // next-PC control from the control unit
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic        stall,
  // instruction memory port
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  // fetch PC and IF/ID register
  output logic [31:0] pc,
  output logic [31:0] ID_pc4,
  output logic [31:0] ID_inst,
  output logic        ID_valid
);

  // IDLE  : one dead cycle after reset, no request
  // FETCH : request outstanding at imem_addr = pc
  // HOLD  : returned word sits in the skid buffer while ID is stalled
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [1:0]  PCSRC_SEQ  = 2'd0;
  localparam logic [1:0]  PCSRC_BR   = 2'd1;
  localparam logic [1:0]  PCSRC_JR   = 2'd2;
  localparam logic [1:0]  PCSRC_JMP  = 2'd3;
  localparam logic [31:0] NOP_INST   = 32'h0000_0000;

  // ---------------------------------------------------------------------------
  // State and registered datapath
  // ---------------------------------------------------------------------------
  state_t      state,        state_n;
  logic [31:0] pc_r,         pc_n;
  logic [31:0] id_pc4_r,     id_pc4_n;
  logic [31:0] id_inst_r,    id_inst_n;
  logic        id_valid_r,   id_valid_n;
  logic        pend_valid,   pend_valid_n;
  logic [31:0] pend_target,  pend_target_n;
  logic [31:0] skid_buf,     skid_buf_n;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [31:0] pc_plus4;
  logic [31:0] raw_target;
  logic [31:0] redirect_target;
  logic        redirect;
  logic [31:0] squash_target;

  // Sequential successor; 32-bit add wraps naturally at 2^32.
  assign pc_plus4 = pc_r + 32'd4;

  // Stall has priority: a redirect is only recognised when ID is moving.
  assign redirect = (pcsource != PCSRC_SEQ) && !stall;

  // Select the redirect target by pcsource.
  always_comb begin
    raw_target = pc_plus4;
    case (pcsource)
      PCSRC_BR:  raw_target = bpc;
      PCSRC_JR:  raw_target = rpc;
      PCSRC_JMP: raw_target = jpc;
      default:   raw_target = pc_plus4;
    endcase
  end

  // Instruction addresses are word aligned; low bits of any target are dropped.
  assign redirect_target = {raw_target[31:2], 2'b00};

  // A redirect seen this cycle overrides one remembered from a wait cycle.
  assign squash_target = redirect ? redirect_target : pend_target;

  // ---------------------------------------------------------------------------
  // State register: all stage state updates on the rising clock edge
  // ---------------------------------------------------------------------------
  // Asynchronous reset forces the whole stage to its post-reset values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      pc_r        <= RESET_PC;
      id_pc4_r    <= 32'h0000_0000;
      id_inst_r   <= NOP_INST;
      id_valid_r  <= 1'b0;
      pend_valid  <= 1'b0;
      pend_target <= 32'h0000_0000;
      skid_buf    <= 32'h0000_0000;
    end else begin
      state       <= state_n;
      pc_r        <= pc_n;
      id_pc4_r    <= id_pc4_n;
      id_inst_r   <= id_inst_n;
      id_valid_r  <= id_valid_n;
      pend_valid  <= pend_valid_n;
      pend_target <= pend_target_n;
      skid_buf    <= skid_buf_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: every register holds unless a case below moves it
  // ---------------------------------------------------------------------------
  // Next state, next PC, IF/ID update, pending redirect and skid buffer.
  always_comb begin
    state_n       = state;
    pc_n          = pc_r;
    id_pc4_n      = id_pc4_r;
    id_inst_n     = id_inst_r;
    id_valid_n    = id_valid_r;
    pend_valid_n  = pend_valid;
    pend_target_n = pend_target;
    skid_buf_n    = skid_buf;

    case (state)
      S_IDLE: begin
        // No request yet; any stray ack is ignored.
        state_n = S_FETCH;
      end

      S_FETCH: begin
        if (imem_ack) begin
          if (stall) begin
            // ID cannot accept: park the word and stop requesting.
            skid_buf_n = imem_rdata;
            state_n    = S_HOLD;
          end else if (redirect || pend_valid) begin
            // Word is from the wrong path: drop it and steer the PC.
            pc_n         = squash_target;
            pend_valid_n = 1'b0;
            id_valid_n   = 1'b0;
            id_inst_n    = NOP_INST;
          end else begin
            id_pc4_n   = pc_plus4;
            id_inst_n  = imem_rdata;
            id_valid_n = 1'b1;
            pc_n       = pc_plus4;
          end
        end else begin
          // Address must stay stable until ack; remember the redirect instead.
          if (redirect) begin
            pend_valid_n  = 1'b1;
            pend_target_n = redirect_target;
          end
          if (!stall) begin
            id_valid_n = 1'b0;
            id_inst_n  = NOP_INST;
          end
        end
      end

      S_HOLD: begin
        if (!stall) begin
          state_n = S_FETCH;
          if (redirect || pend_valid) begin
            pc_n         = squash_target;
            pend_valid_n = 1'b0;
            id_valid_n   = 1'b0;
            id_inst_n    = NOP_INST;
          end else begin
            id_pc4_n   = pc_plus4;
            id_inst_n  = skid_buf;
            id_valid_n = 1'b1;
            pc_n       = pc_plus4;
          end
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc_r;
  assign pc        = pc_r;
  assign ID_pc4    = id_pc4_r;
  assign ID_inst   = id_inst_r;
  assign ID_valid  = id_valid_r;

endmodule

`default_nettype wire

// File: tb/tb_pipe_if_stage.sv
// ============================================================================
// Module   : tb_pipe_if_stage
// Brief    : Directed self-checking bench for pipe_if_stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_if_stage;

  logic        clock;
  logic        reset;
  logic [1:0]  pcsource;
  logic [31:0] bpc, rpc, jpc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc, ID_pc4, ID_inst;
  logic        ID_valid;

  logic        auto_ack;
  logic        man_ack;

  int compared   = 0;
  int mismatched = 0;

  logic [129:0] obs;
  logic [129:0] exp_v;

  // Address-tagged memory contents.
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Expected snapshot: {imem_req, imem_addr, pc, ID_valid, ID_inst, ID_pc4}.
  function automatic logic [129:0] pack(input logic req, input logic [31:0] p,
                                        input logic v, input logic [31:0] inst,
                                        input logic [31:0] p4);
    return {req, p, p, v, inst, p4};
  endfunction

  assign obs        = {imem_req, imem_addr, pc, ID_valid, ID_inst, ID_pc4};
  assign imem_ack   = auto_ack ? imem_req : man_ack;
  assign imem_rdata = word(imem_addr);

  pipe_if_stage dut (
    .clock      (clock),
    .reset      (reset),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .rpc        (rpc),
    .jpc        (jpc),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .ID_pc4     (ID_pc4),
    .ID_inst    (ID_inst),
    .ID_valid   (ID_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) step();
    exp_v = pack(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL reset got %h exp %h", obs, exp_v); end
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    step();
    exp_v = pack(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL seq_idle got %h exp %h", obs, exp_v); end
    for (int i = 1; i <= 3; i++) begin
      step();
      exp_v = pack(1'b1, 32'(4*i), 1'b1, word(32'(4*(i-1))), 32'(4*i));
      compared++;
      if (obs !== exp_v) begin mismatched++; $display("FAIL seq%0d got %h exp %h", i, obs, exp_v); end
    end
  endtask

  task automatic test_wait_states();
    pcsource = 2'd3; jpc = 32'h10;
    step();
    exp_v = pack(1'b1, 32'h10, 1'b0, 32'h0, 32'hC);
    compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL wait_jump got %h exp %h", obs, exp_v); end
    pcsource = 2'd0; auto_ack = 1'b0; man_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_v = pack(1'b1, 32'h10, 1'b0, 32'h0, 32'hC);
      compared++;
      if (obs !== exp_v) begin mismatched++; $display("FAIL wait_hold%0d got %h exp %h", i, obs, exp_v); end
    end
    man_ack = 1'b1;
    step();
    exp_v = pack(1'b1, 32'h14, 1'b1, word(32'h10), 32'h14);
    compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL wait_load got %h exp %h", obs, exp_v); end
  endtask

  task automatic test_stall_hold();
    pcsource = 2'd3; jpc = 32'h20;
    step();
    exp_v = pack(1'b1, 32'h20, 1'b0, 32'h0, 32'h14);
    compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL stall_jump got %h exp %h", obs, exp_v); end
    pcsource = 2'd0; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      exp_v = pack(1'b0, 32'h20, 1'b0, 32'h0, 32'h14);
      compared++;
      if (obs !== exp_v) begin mismatched++; $display("FAIL stall_hold%0d got %h exp %h", i, obs, exp_v); end
    end
    stall = 1'b0;
    step();
    exp_v = pack(1'b1, 32'h24, 1'b1, word(32'h20), 32'h24);
    compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL stall_release got %h exp %h", obs, exp_v); end
  endtask

  task automatic test_branch_squash();
    pcsource = 2'd1; bpc = 32'h100;
    step();
    exp_v = pack(1'b1, 32'h100, 1'b0, 32'h0, 32'h24);
    compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL branch got %h exp %h", obs, exp_v); end
    pcsource = 2'd0;
  endtask

  task automatic test_pending_redirect();
    man_ack = 1'b0; pcsource = 2'd2; rpc = 32'h203;
    step();
    exp_v = pack(1'b1, 32'h100, 1'b0, 32'h0, 32'h24);
    compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL pend_wait0 got %h exp %h", obs, exp_v); end
    pcsource = 2'd0;
    step();
    compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL pend_wait1 got %h exp %h", obs, exp_v); end
    man_ack = 1'b1;
    step();
    exp_v = pack(1'b1, 32'h200, 1'b0, 32'h0, 32'h24);
    compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL pend_take got %h exp %h", obs, exp_v); end
    step();
    exp_v = pack(1'b1, 32'h204, 1'b1, word(32'h200), 32'h204);
    compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL pend_after got %h exp %h", obs, exp_v); end
    // a later redirect during the wait replaces the remembered one
    man_ack = 1'b0; pcsource = 2'd2; rpc = 32'h300;
    step();
    pcsource = 2'd3; jpc = 32'h401;
    step();
    pcsource = 2'd0; man_ack = 1'b1;
    step();
    exp_v = pack(1'b1, 32'h400, 1'b0, 32'h0, 32'h204);
    compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL pend_overwrite got %h exp %h", obs, exp_v); end
    // a redirect in the ack cycle beats the pending one
    man_ack = 1'b0; pcsource = 2'd1; bpc = 32'h500;
    step();
    man_ack = 1'b1; pcsource = 2'd3; jpc = 32'h600;
    step();
    exp_v = pack(1'b1, 32'h600, 1'b0, 32'h0, 32'h204);
    compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL pend_override got %h exp %h", obs, exp_v); end
    pcsource = 2'd0;
  endtask

  task automatic test_wrap_and_stall_priority();
    pcsource = 2'd3; jpc = 32'hFFFF_FFFF;
    step();
    exp_v = pack(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h204);
    compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL wrap_jump got %h exp %h", obs, exp_v); end
    pcsource = 2'd0;
    step();
    exp_v = pack(1'b1, 32'h0, 1'b1, word(32'hFFFF_FFFC), 32'h0);
    compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL wrap_seq got %h exp %h", obs, exp_v); end
    stall = 1'b1; pcsource = 2'd3; jpc = 32'h300;
    for (int i = 0; i < 2; i++) begin
      step();
      exp_v = pack(1'b0, 32'h0, 1'b1, word(32'hFFFF_FFFC), 32'h0);
      compared++;
      if (obs !== exp_v) begin mismatched++; $display("FAIL stallprio%0d got %h exp %h", i, obs, exp_v); end
    end
    stall = 1'b0; pcsource = 2'd0;
    step();
    exp_v = pack(1'b1, 32'h4, 1'b1, word(32'h0), 32'h4);
    compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL stallprio_release got %h exp %h", obs, exp_v); end
  endtask

  task automatic test_reset_midfetch();
    man_ack = 1'b0;
    step();
    exp_v = pack(1'b1, 32'h4, 1'b0, 32'h0, 32'h4);
    compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL mid_wait got %h exp %h", obs, exp_v); end
    reset = 1'b1;
    #1;
    exp_v = pack(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL mid_async got %h exp %h", obs, exp_v); end
    man_ack = 1'b1;
    step();
    compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL mid_inreset got %h exp %h", obs, exp_v); end
    reset = 1'b0;
    step();
    exp_v = pack(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL mid_lateack got %h exp %h", obs, exp_v); end
    step();
    exp_v = pack(1'b1, 32'h4, 1'b1, word(32'h0), 32'h4);
    compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL mid_resume got %h exp %h", obs, exp_v); end
  endtask

  initial begin
    reset    = 1'b1;
    pcsource = 2'd0;
    bpc      = 32'h0;
    rpc      = 32'h0;
    jpc      = 32'h0;
    stall    = 1'b0;
    auto_ack = 1'b1;
    man_ack  = 1'b0;

    test_reset();
    test_sequential();
    test_wait_states();
    test_stall_hold();
    test_branch_squash();
    test_pending_redirect();
    test_wrap_and_stall_priority();
    test_reset_midfetch();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
